// File: rtl/mag_sq_pkg.sv
// Shared definitions for the squared-magnitude feeder.
//   MAG_SQ_DATA_W  : signed width of each input component
//   MAG_SQ_OUT_W   : width of the squared-magnitude result
//   MAG_SQ_SHIFT_W : width of the normalisation shift k
//   MAG_SQ_LZC_W   : width of the leading-zero count (0..MAG_SQ_OUT_W)
//   mag_sq_out_t   : payload of the stage that drives the output port
package mag_sq_pkg;

  localparam int unsigned MAG_SQ_DATA_W  = 32;
  localparam int unsigned MAG_SQ_OUT_W   = 64;
  localparam int unsigned MAG_SQ_SHIFT_W = 6;
  localparam int unsigned MAG_SQ_LZC_W   = 7;

  typedef struct packed {
    logic [MAG_SQ_OUT_W-1:0]   data;
    logic [MAG_SQ_SHIFT_W-1:0] shift;
  } mag_sq_out_t;

endpackage

// File: rtl/mag_sq_lzc.sv
// Combinational leading-zero counter over a 64-bit word.
//   data_i  : word to scan, MSB first
//   count_o : number of leading zeros, 64 when data_i is zero
module mag_sq_lzc
  import mag_sq_pkg::*;
(
  input  logic [MAG_SQ_OUT_W-1:0] data_i,
  output logic [MAG_SQ_LZC_W-1:0] count_o
);

  // Scan LSB to MSB; the last set bit seen is the most significant one.
  always_comb begin
    count_o = MAG_SQ_LZC_W'(MAG_SQ_OUT_W);
    for (int unsigned i = 0; i < MAG_SQ_OUT_W; i++) begin
      if (data_i[i]) begin
        count_o = MAG_SQ_LZC_W'(MAG_SQ_OUT_W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/mag_sq_feeder.sv
// Squared-magnitude front end for the 64-bit integer square-root core.
// Accepts signed (x, y) pairs and emits x*x + y*y through a stallable
// 3-stage pipeline (|x|,|y| -> squares -> sum).
// Optional feature macro MAG_SQ_NORM_EN adds a fourth stage that shifts the
// sum left by 2k so its top two bits are non-zero and reports k.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake, in_x / in_y signed components
//   out_valid/out_ready : output handshake
//   out_data            : squared magnitude (normalised with the macro)
//   out_shift           : normalisation shift k (0 without the macro)
module mag_sq_feeder
  import mag_sq_pkg::*;
#(
  parameter int unsigned DATA_W = MAG_SQ_DATA_W,
  parameter int unsigned OUT_W  = MAG_SQ_OUT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_x,
  input  logic [DATA_W-1:0]         in_y,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic [MAG_SQ_SHIFT_W-1:0] out_shift
);

  localparam int unsigned SqW = 2 * DATA_W - 1;

  logic              advance;
  logic              v_last;
  mag_sq_out_t       fin;

  logic              v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [DATA_W-1:0] ax_q, ax_d, ay_q, ay_d;
  logic [SqW-1:0]    sx_q, sx_d, sy_q, sy_d;
  logic [SqW-1:0]    ax_ext, ay_ext;
  logic [OUT_W-1:0]  sum_q, sum_d;

  // One global enable: every stage moves together, bubbles included.
  assign advance  = !v_last || out_ready;
  assign in_ready = advance && !rst;

  // Squares are formed at SqW bits; (2^(DATA_W-1))^2 still fits.
  assign ax_ext = SqW'(ax_q);
  assign ay_ext = SqW'(ay_q);

  always_comb begin
    v1_d  = v1_q;
    v2_d  = v2_q;
    v3_d  = v3_q;
    ax_d  = ax_q;
    ay_d  = ay_q;
    sx_d  = sx_q;
    sy_d  = sy_q;
    sum_d = sum_q;
    if (advance) begin
      v1_d  = in_valid && in_ready;
      v2_d  = v1_q;
      v3_d  = v2_q;
      // Two's-complement negate as unsigned: -2^(DATA_W-1) maps to 2^(DATA_W-1).
      ax_d  = in_x[DATA_W-1] ? (~in_x + DATA_W'(1)) : in_x;
      ay_d  = in_y[DATA_W-1] ? (~in_y + DATA_W'(1)) : in_y;
      sx_d  = ax_ext * ax_ext;
      sy_d  = ay_ext * ay_ext;
      sum_d = OUT_W'(sx_q) + OUT_W'(sy_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      ax_q  <= '0;
      ay_q  <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
      sum_q <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      ax_q  <= ax_d;
      ay_q  <= ay_d;
      sx_q  <= sx_d;
      sy_q  <= sy_d;
      sum_q <= sum_d;
    end
  end

`ifdef MAG_SQ_NORM_EN
  logic [MAG_SQ_LZC_W-1:0]   lzc;
  logic [MAG_SQ_SHIFT_W-1:0] k;
  logic                      v4_q, v4_d;
  mag_sq_out_t               s4_q, s4_d;

  mag_sq_lzc u_lzc (
    .data_i  (sum_q),
    .count_o (lzc)
  );

  // k = floor(lzc/2); a zero sum would give k = 32, so force it to 0.
  assign k = (sum_q == '0) ? '0 : MAG_SQ_SHIFT_W'(lzc >> 1);

  always_comb begin
    v4_d = v4_q;
    s4_d = s4_q;
    if (advance) begin
      v4_d       = v3_q;
      s4_d.data  = sum_q << {k, 1'b0};
      s4_d.shift = k;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v4_q <= 1'b0;
      s4_q <= '0;
    end else begin
      v4_q <= v4_d;
      s4_q <= s4_d;
    end
  end

  assign v_last = v4_q;
  assign fin    = s4_q;
`else
  assign v_last = v3_q;
  assign fin    = '{data: sum_q, shift: '0};
`endif

  assign out_valid = v_last;
  assign out_data  = fin.data;
  assign out_shift = fin.shift;

endmodule

// File: doc/mag_sq_feeder.md
# mag_sq_feeder

Front-end stage that sits directly upstream of the 64-bit integer square-root core. It accepts signed 2-D vector pairs (x, y) with a valid/ready handshake and computes the unsigned squared magnitude x² + y² in a stallable pipeline. It presents that value on a 64-bit valid/ready output that drives the sqrt core's `sqrt_data` input, so the pair yields |v| = sqrt(x² + y²).

## Interface
- `DATA_W`, 32: signed width of each input component.
- `OUT_W`, 2*DATA_W: output width; must equal 2*DATA_W, 64 at default.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input pair valid.
- `in_ready`  out  1  stage can accept a pair this cycle.
- `in_x`  in  DATA_W  signed x component.
- `in_y`  in  DATA_W  signed y component.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  downstream (sqrt core) accepts.
- `out_data`  out  OUT_W  unsigned x² + y²; normalised when `MAG_SQ_NORM_EN` is defined.
- `out_shift`  out  6  normalisation shift k; constant 0 when the macro is not defined.

## Operation
- Transfers:
  - Input transfer occurs when `in_valid` and `in_ready` are both high.
  - Output transfer occurs when `out_valid` and `out_ready` are both high.
- Pipeline has three stages, each with its own valid bit:
  - S1 registers |x| and |y| as DATA_W-bit unsigned values. |−2^(DATA_W−1)| = 2^(DATA_W−1) must be exact, with no wrap.
  - S2 registers x² and y², each 2*DATA_W−1 bits unsigned.
  - S3 registers the sum zero-extended to OUT_W. The maximum is 2^(2*DATA_W−1) (0x8000_0000_0000_0000 at default); no overflow is possible.
- Global stall:
  - `advance = !v_last || out_ready`, where v_last is the valid bit of the final stage.
  - All stages load only when `advance` is high. Bubbles are not collapsed.
- `in_ready = advance && !rst`.
- `out_valid` equals v_last, and `out_data`/`out_shift` come directly from the final-stage registers.
- While `out_valid` is high and `out_ready` is low, `out_data` and `out_shift` hold stable.
- Results are emitted strictly in acceptance order. No pair is ever dropped or duplicated.
- Reset (synchronous, including mid-operation):
  - All valid bits clear; in-flight pairs are discarded.
  - `out_valid` = 0, `out_data` = 0, `out_shift` = 0.
  - `in_ready` = 0 while `rst` is high.

## Timing
- Latency: 3 cycles from input transfer to `out_valid` when unstalled; 4 cycles with `MAG_SQ_NORM_EN`.
- Throughput: one pair per cycle while `out_ready` is held high.
- Capacity: 3 pairs in flight (4 with the macro). Once full with `out_ready` low, `in_ready` is 0 in the same cycle.
- `in_ready` is combinational from `out_ready` and v_last. `out_valid` does not depend combinationally on any input.

## Configuration
- `MAG_SQ_NORM_EN` defined:
  - Adds stage S4 after S3.
  - lzc = leading-zero count of the S3 sum; k = floor(lzc/2).
  - `out_data` = sum << 2k, so the top two bits are non-zero; `out_shift` = k.
  - Downstream recovers the root as sqrt(out_data) >> k.
  - Zero sum gives `out_data` = 0, `out_shift` = 0.
- Undefined:
  - S4 is absent and latency is 3.
  - `out_data` is the raw sum; `out_shift` is tied to 0.

## Structure
- Shared package `mag_sq_pkg` holds:
  - `MAG_SQ_DATA_W` = 32.
  - `MAG_SQ_OUT_W` = 64.
  - `MAG_SQ_SHIFT_W` = 6.
  - The typedef for the pipeline stage payload.
- Sub-module `mag_sq_lzc`: a purely combinational 64-bit leading-zero counter with a 7-bit output. It is instantiated only under `MAG_SQ_NORM_EN`.

## Test plan
- x=3, y=4, `out_ready`=1:
  - `out_data`=25, `out_shift`=0.
  - `out_valid` rises 3 cycles after acceptance.
- x=−2147483648, y=−2147483648 → `out_data`=0x8000_0000_0000_0000 (no wrap). Then x=−1, y=0 → 1.
- `out_ready`=0 with 5 pairs offered back-to-back:
  - Exactly 3 are accepted, then `in_ready`=0 and `out_data` holds stable.
  - Raise `out_ready`; all 5 results emerge in order: 1, 4, 9, 16, 25 for x=1..5, y=0.
- 2 pairs in flight, `rst` pulsed for 1 cycle:
  - Next cycle `out_valid`=0, `out_data`=0.
  - Neither result is ever emitted; a pair accepted after reset emits normally.
- `out_ready`=1, 8 consecutive pairs (x=i, y=i):
  - One result per cycle: 2·i².
  - `in_ready` stays 1 throughout.
- With `MAG_SQ_NORM_EN`:
  - x=0, y=4 → `out_data`=0x4000_0000_0000_0000, `out_shift`=29, latency 4.
  - x=0, y=0 → `out_data`=0, `out_shift`=0.
